sync_fifo_param: RTL

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 119 +++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO. Reads have one cycle of latency through
// a registered rdata. Status flags are decoded from a registered occupancy
// count. Overflow and underflow are sticky error flags.
//
// Handshake: wr_en and rd_en are requests, not valid/ready pairs.
// - A write is taken when wr_en=1 and either the FIFO is not full, or a read
//   is taken in the same cycle.
// - A read is taken when rd_en=1 and the FIFO is not empty.
// - rd_valid is 1 for exactly the cycle after a taken read, when rdata holds
//   the popped word.
// - A refused request is dropped, not held. The matching sticky error flag
//   records it.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd_en,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     almost_full,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic wr_accept;
    logic rd_accept;
    logic wr_reject;
    logic rd_reject;

    // Status flags come only from the count register, so no input reaches an output.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    // Accept/reject decisions. When full, a write may still be taken if a read frees a slot in the same cycle.
    always_comb begin
        rd_accept = 1'b0;
        wr_accept = 1'b0;
        rd_accept = rd_en && !empty;
        wr_accept = wr_en && (!full || rd_accept);
        wr_reject = wr_en && !wr_accept;
        rd_reject = rd_en && !rd_accept;
    end

    // Storage array. It is never reset; the pointers and count keep stale entries unreachable.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy, registered read data and read-valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rdata    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rdata  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags. A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_reject) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_reject) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
